// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I field bundles into instruction words and streams them into IMEM.
// Two stages: stage1 captures the bundle, stage2 holds the range-checked encoded word until IMEM takes it.
module instr_encoder_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] word_count,
    output logic        wrapped
);

    localparam logic [31:0] LAST_ADDR = ADDR_BASE + 32'(4 * (DEPTH - 1));
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic        s1_full;
    logic        s2_full;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_op;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic        s2_can_take;
    logic        accept;
    logic        transfer;
    logic        write_done;
    logic        legal;
    logic [31:0] word;
    logic signed [31:0] simm;

    assign s2_can_take = !s2_full || imem_ready;
    assign in_ready    = !s1_full || s2_can_take;
    assign accept      = in_valid && in_ready;
    assign transfer    = s1_full && s2_can_take;
    assign write_done  = s2_full && imem_ready;
    assign imem_we     = s2_full;
    assign simm        = $signed(s1_imm);

    // Field packing and immediate range check for the bundle sitting in stage1.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (s1_fmt)
            3'd0: begin
                word  = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
                legal = 1'b1;
            end
            3'd1: begin
                word  = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd2: begin
                word  = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd3: begin
                word  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                         s1_imm[4:1], s1_imm[11], s1_op};
                legal = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !s1_imm[0];
            end
            3'd4: begin
                word  = {s1_imm[31:12], s1_rd, s1_op};
                legal = (s1_imm[11:0] == 12'd0);
            end
            3'd5: begin
                word  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
                legal = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !s1_imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Stage1 field capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_fmt <= '0;
            s1_op  <= '0;
            s1_f3  <= '0;
            s1_f7  <= '0;
            s1_rd  <= '0;
            s1_rs1 <= '0;
            s1_rs2 <= '0;
            s1_imm <= '0;
        end else if (accept) begin
            s1_fmt <= fmt;
            s1_op  <= opcode;
            s1_f3  <= funct3;
            s1_f7  <= funct7;
            s1_rd  <= rd;
            s1_rs1 <= rs1;
            s1_rs2 <= rs2;
            s1_imm <= imm;
        end
    end

    // Pipeline occupancy, write address, counters and flags; clear outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full    <= 1'b0;
            s2_full    <= 1'b0;
            imem_addr  <= ADDR_BASE;
            imem_wdata <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
            wrapped    <= 1'b0;
        end else if (clear) begin
            s1_full    <= 1'b0;
            s2_full    <= 1'b0;
            imem_addr  <= ADDR_BASE;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
            wrapped    <= 1'b0;
        end else begin
            err_pulse <= transfer && !legal;
            if (transfer && !legal && err_count != CNT_MAX) begin
                err_count <= err_count + 16'd1;
            end

            if (accept) begin
                s1_full <= 1'b1;
            end else if (transfer) begin
                s1_full <= 1'b0;
            end

            if (transfer && legal) begin
                s2_full    <= 1'b1;
                imem_wdata <= word;
            end else if (write_done) begin
                s2_full <= 1'b0;
            end

            if (write_done) begin
                if (word_count != CNT_MAX) begin
                    word_count <= word_count + 16'd1;
                end
                if (imem_addr == LAST_ADDR) begin
                    imem_addr <= ADDR_BASE;
                    wrapped   <= 1'b1;
                end else begin
                    imem_addr <= imem_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised and directed bench for instr_encoder_loader against an arithmetic reference encoder.
// Uses a small DEPTH and a non-zero base so address wrap is exercised quickly.
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic        wrapped;

    instr_encoder_loader #(.ADDR_BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count), .wrapped(wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_w[$];
    int n_pulse = 0;
    int n_we = 0;
    int model_words = 0;
    int model_err = 0;
    bit rand_ready = 1'b0;

    // Records completed writes and pulse activity away from the active edge.
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (imem_we && imem_ready) begin
                wa.push_back(imem_addr);
                wd.push_back(imem_wdata);
            end
            if (err_pulse) n_pulse++;
            if (imem_we) n_we++;
        end
    end

    function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
        int unsigned mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & mask;
    endfunction

    // Instruction word built by weighting each field by its bit position.
    function automatic void ref_encode(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [4:0] d_, input logic [4:0] a_,
                                       input logic [4:0] b_, input logic [31:0] im,
                                       output bit ok, output logic [31:0] w);
        int unsigned o, d, a, b, c, s7, u, r;
        int si;
        o = 32'(op); d = 32'(d_); a = 32'(a_); b = 32'(b_); c = 32'(f3); s7 = 32'(f7); u = im;
        si = $signed(im);
        r = 0;
        ok = 1'b0;
        case (f)
            3'd0: begin ok = 1'b1; r = o + (d << 7) + (c << 12) + (a << 15) + (b << 20) + (s7 << 25); end
            3'd1: begin
                ok = (si >= -2048) && (si <= 2047);
                r = o + (d << 7) + (c << 12) + (a << 15) + (fld(u, 11, 0) << 20);
            end
            3'd2: begin
                ok = (si >= -2048) && (si <= 2047);
                r = o + (fld(u, 4, 0) << 7) + (c << 12) + (a << 15) + (b << 20) + (fld(u, 11, 5) << 25);
            end
            3'd3: begin
                ok = (si >= -4096) && (si <= 4094) && (u % 2 == 0);
                r = o + (fld(u, 11, 11) << 7) + (fld(u, 4, 1) << 8) + (c << 12) + (a << 15) + (b << 20)
                    + (fld(u, 10, 5) << 25) + (fld(u, 12, 12) << 31);
            end
            3'd4: begin
                ok = (u % 4096 == 0);
                r = o + (d << 7) + (u / 4096) * 4096;
            end
            3'd5: begin
                ok = (si >= -1048576) && (si <= 1048574) && (u % 2 == 0);
                r = o + (d << 7) + (fld(u, 19, 12) << 12) + (fld(u, 11, 11) << 20) + (fld(u, 10, 1) << 21)
                    + (fld(u, 20, 20) << 31);
            end
            default: ok = 1'b0;
        endcase
        w = r;
    endfunction

    // Presents one bundle until accepted; caller is positioned 1ns after a rising edge.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d_, input logic [4:0] a_, input logic [4:0] b_,
                        input logic [31:0] im, output int waited);
        bit ok;
        bit acc;
        logic [31:0] w;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d_; rs1 = a_; rs2 = b_; imm = im;
        in_valid = 1'b1;
        waited = 0;
        do begin
            if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            if (!acc) waited++;
            @(posedge clk);
            #1;
        end while (!acc && waited < 200);
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waited);
        end
        ref_encode(f, op, f3, f7, d_, a_, b_, im, ok, w);
        if (ok) begin
            exp_w.push_back(w);
            exp_a.push_back(BASE + 32'(4 * (model_words % DEPTH)));
            model_words++;
        end else begin
            model_err++;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        imem_ready = 1'b1;
        while ((cyc < 3 || wa.size() < exp_w.size() || imem_we) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d writes, required %0d", wa.size(), exp_w.size());
        end
    endtask

    task automatic flush();
        wa.delete(); wd.delete(); exp_a.delete(); exp_w.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_words = 0;
        model_err = 0;
        flush();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== BASE || imem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_io: ready=%b we=%b addr=%h wdata=%h, required 1 0 %h 0",
                     in_ready, imem_we, imem_addr, imem_wdata, BASE);
        end
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd0 || word_count !== 16'd0 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: pulse=%b errc=%0d words=%0d wrapped=%b, required all 0",
                     err_pulse, err_count, word_count, wrapped);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_words = 0;
        model_err = 0;
        flush();
    endtask

    task automatic test_addi();
        int wt;
        imem_ready = 1'b1;
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, wt);
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++; $display("FAIL addi_stage1: imem_we=%b, required 0", imem_we);
        end
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== BASE || imem_wdata !== 32'h0050_0093) begin
            errors++;
            $display("FAIL addi_write: we=%b addr=%h wdata=%h, required 1 %h 00500093",
                     imem_we, imem_addr, imem_wdata, BASE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (word_count !== 16'd1 || imem_addr !== BASE + 32'd4) begin
            errors++;
            $display("FAIL addi_done: words=%0d addr=%h, required 1 %h", word_count, imem_addr, BASE + 32'd4);
        end
        wait_drain();
        flush();
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        imem_ready = 1'b1;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, w1);
        send(3'd2, 7'h23, 3'd2, 7'h55, 5'd9, 5'd1, 5'd2, 32'd8, w2);
        checks++;
        if (w1 != 0 || w2 != 0) begin
            errors++; $display("FAIL b2b_ready: stall cycles %0d/%0d, required 0/0", w1, w2);
        end
        wait_drain();
        checks++;
        if (wd.size() != 2 || wd[0] !== 32'h0020_81B3 || wd[1] !== 32'h0020_A423
            || wa[0] !== exp_a[0] || wa[1] !== exp_a[1]) begin
            errors++;
            $display("FAIL b2b_words: n=%0d w0=%h w1=%h a0=%h, required 2 002081b3 0020a423 %h",
                     wd.size(), wd.size() > 0 ? wd[0] : 32'hx, wd.size() > 1 ? wd[1] : 32'hx,
                     wa.size() > 0 ? wa[0] : 32'hx, exp_a[0]);
        end
        flush();
    endtask

    task automatic test_known();
        int wt;
        logic [31:0] want[3];
        want[0] = 32'hFE20_8EE3; want[1] = 32'h0080_00EF; want[2] = 32'h1234_52B7;
        imem_ready = 1'b1;
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, wt);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, wt);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, wt);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wd.size() || wd[i] !== want[i] || wa[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL known_%0d: wdata=%h addr=%h, required %h %h", i,
                         i < wd.size() ? wd[i] : 32'hx, i < wa.size() ? wa[i] : 32'hx, want[i], exp_a[i]);
            end
        end
        flush();
    endtask

    task automatic test_errors();
        int wt, p0, w0;
        logic [31:0] a0;
        imem_ready = 1'b1;
        do_clear();
        p0 = n_pulse; w0 = n_we; a0 = imem_addr;
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, wt);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, wt);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, wt);
        wait_drain();
        checks++;
        if (n_pulse - p0 != 3 || err_count !== 16'd3) begin
            errors++; $display("FAIL err_count: pulses=%0d count=%0d, required 3 3", n_pulse - p0, err_count);
        end
        checks++;
        if (n_we != w0 || wa.size() != 0 || imem_addr !== a0) begin
            errors++; $display("FAIL err_nowrite: we_cycles=%0d addr=%h, required 0 %h", n_we - w0, imem_addr, a0);
        end
    endtask

    task automatic test_boundaries();
        int wt;
        logic [31:0] ims[13];
        logic [2:0]  fs[13];
        fs  = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd2, 3'd2};
        ims = '{-32'sd2048, 32'd2047, -32'sd2049, 32'd4094, -32'sd4096, 32'd4096,
                32'd1048574, -32'sd1048576, 32'd1048576, 32'h0000_1000, 32'h0000_0800,
                -32'sd2048, 32'd2048};
        do_clear();
        for (int i = 0; i < 13; i++) begin
            send(fs[i], 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), ims[i], wt);
        end
        wait_drain();
        checks++;
        if (err_count !== 16'd5 || model_err != 5 || wa.size() != 8) begin
            errors++; $display("FAIL bound_count: errs=%0d writes=%0d, required 5 8", err_count, wa.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wd.size() || wd[i] !== exp_w[i] || wa[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL bound_word_%0d: wdata=%h addr=%h, required %h %h", i,
                         i < wd.size() ? wd[i] : 32'hx, i < wa.size() ? wa[i] : 32'hx, exp_w[i], exp_a[i]);
            end
        end
        flush();
    endtask

    task automatic test_stall();
        int w1, w2, wt;
        do_clear();
        imem_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0, w1);
        send(3'd1, 7'h13, 3'd1, 7'd0, 5'd7, 5'd8, 5'd0, 32'd77, w2);
        checks++;
        if (w1 != 0 || w2 != 0) begin
            errors++; $display("FAIL stall_accepts: stall cycles %0d/%0d, required 0/0", w1, w2);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== exp_a[0] || imem_wdata !== exp_w[0]) begin
                errors++;
                $display("FAIL stall_hold: ready=%b we=%b addr=%h wdata=%h, required 0 1 %h %h",
                         in_ready, imem_we, imem_addr, imem_wdata, exp_a[0], exp_w[0]);
            end
        end
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, -32'sd12, wt);
        send(3'd4, 7'h17, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCD_E000, wt);
        wait_drain();
        checks++;
        if (wd.size() != 4) begin
            errors++; $display("FAIL stall_count: writes=%0d, required 4", wd.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wd.size() || wd[i] !== exp_w[i] || wa[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL stall_word_%0d: wdata=%h addr=%h, required %h %h", i,
                         i < wd.size() ? wd[i] : 32'hx, i < wa.size() ? wa[i] : 32'hx, exp_w[i], exp_a[i]);
            end
        end
        flush();
    endtask

    task automatic test_random();
        int wt, p0;
        logic [31:0] im;
        do_clear();
        p0 = n_pulse;
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: im = $urandom;
                2: im = $urandom & 32'hFFFF_F000;
                default: im = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
            endcase
            send(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), im, wt);
        end
        rand_ready = 1'b0;
        wait_drain();
        checks++;
        if (err_count !== 16'(model_err) || n_pulse - p0 != model_err) begin
            errors++;
            $display("FAIL rand_errs: count=%0d pulses=%0d, required %0d", err_count, n_pulse - p0, model_err);
        end
        checks++;
        if (word_count !== 16'(model_words) || wrapped !== (model_words >= DEPTH) || wd.size() != exp_w.size()) begin
            errors++;
            $display("FAIL rand_words: words=%0d wrapped=%b writes=%0d, required %0d %b %0d",
                     word_count, wrapped, wd.size(), model_words, model_words >= DEPTH, exp_w.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wd.size() || wd[i] !== exp_w[i] || wa[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL rand_word_%0d: wdata=%h addr=%h, required %h %h", i,
                         i < wd.size() ? wd[i] : 32'hx, i < wa.size() ? wa[i] : 32'hx, exp_w[i], exp_a[i]);
            end
        end
        flush();
    endtask

    task automatic test_clear_wrap();
        int wt;
        do_clear();
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), wt);
        end
        wait_drain();
        checks++;
        if (wa.size() != 5 || wa[4] !== BASE || wrapped !== 1'b1 || word_count !== 16'd5) begin
            errors++;
            $display("FAIL wrap: writes=%0d addr5=%h wrapped=%b words=%0d, required 5 %h 1 5",
                     wa.size(), wa.size() > 4 ? wa[4] : 32'hx, wrapped, word_count, BASE);
        end
        imem_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, wt);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0, wt);
        do_clear();
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== BASE || word_count !== 16'd0 || err_count !== 16'd0
            || wrapped !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: we=%b addr=%h words=%0d errs=%0d wrapped=%b ready=%b, required 0 %h 0 0 0 1",
                     imem_we, imem_addr, word_count, err_count, wrapped, in_ready, BASE);
        end
        imem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 0) begin
            errors++; $display("FAIL clear_drop: writes=%0d, required 0", wa.size());
        end
        imem_ready = 1'b0;
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, wt);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== BASE || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: we=%b addr=%h ready=%b, required 0 %h 1", imem_we, imem_addr, in_ready, BASE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 0 || word_count !== 16'd0) begin
            errors++; $display("FAIL reset_drop: writes=%0d words=%0d, required 0 0", wa.size(), word_count);
        end
        flush();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
        fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_known();
        test_errors();
        test_boundaries();
        test_stall();
        test_random();
        test_clear_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
